// File: rtl/ahblite_timer.sv
// ahblite_timer
//   AHB-Lite slave: a down-counting timer with prescaler, periodic and
//   one-shot modes, and a level interrupt. It has zero wait states and never
//   returns ERROR.
//
//   Register map (word address HADDR[3:2]):
//     0 CTRL   RW  [0]EN [1]IE [2]ONESHOT [8+PRE_W-1:8]PRESCALE
//     1 LOAD   RW  [CNT_W-1:0]
//     2 VALUE  RO  current count
//     3 STATUS     [0]IRQ flag; write 1 to clear
//
// Ports
//   HCLK, HRESET         clock and synchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HSIZE, HWRITE, HREADY address-phase inputs (HSIZE is ignored)
//   HWDATA               write data, sampled in the data phase
//   HREADYOUT, HRESP     tied to 1 and OKAY
//   HRDATA               read data, valid in the read data phase, 0 otherwise
//   TIMER_IRQ            STATUS.IRQ & CTRL.IE
module ahblite_timer #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        TIMER_IRQ
);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_VALUE  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    // State carried from the address phase into the data phase
    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [1:0] addr;
    } dphase_t;

    dphase_t          dp;
    logic             accept;
    logic             wr_ctrl, wr_load, wr_status;
    logic             tick, expire;

    logic             en, ie, oneshot;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] load;
    logic [CNT_W-1:0] value;
    logic             irq;

    // HSIZE and the undecoded address bits carry no meaning for this slave
    logic unused;
    assign unused = ^{HSIZE, HADDR[31:4], HADDR[1:0]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign TIMER_IRQ = irq & ie;

    // ---------------- bus pipeline ----------------
    assign accept = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp <= '0;
        end else begin
            dp.wr   <= accept & HWRITE;
            dp.rd   <= accept & ~HWRITE;
            dp.addr <= accept ? HADDR[3:2] : 2'b00;
        end
    end

    assign wr_ctrl   = dp.wr && (dp.addr == A_CTRL);
    assign wr_load   = dp.wr && (dp.addr == A_LOAD);
    assign wr_status = dp.wr && (dp.addr == A_STATUS);

    // ---------------- counting ----------------
    assign tick   = en && (pre_cnt == prescale);
    assign expire = tick && (value == '0);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            oneshot  <= 1'b0;
            prescale <= '0;
            pre_cnt  <= '0;
            load     <= '0;
            value    <= '0;
            irq      <= 1'b0;
        end else begin
            // A bus write to CTRL overrides the one-shot auto-disable
            if (wr_ctrl) begin
                en       <= HWDATA[0];
                ie       <= HWDATA[1];
                oneshot  <= HWDATA[2];
                prescale <= HWDATA[8 +: PRE_W];
            end else if (expire && oneshot) begin
                en <= 1'b0;
            end

            if (wr_load)
                load <= HWDATA[CNT_W-1:0];

            // Prescaler restarts on a LOAD write and when software turns EN off
            if (wr_load || (wr_ctrl && en && !HWDATA[0]))
                pre_cnt <= '0;
            else if (tick)
                pre_cnt <= '0;
            else if (en)
                pre_cnt <= pre_cnt + 1'b1;

            // LOAD write takes priority over a tick on the same cycle
            if (wr_load) begin
                value <= HWDATA[CNT_W-1:0];
            end else if (tick) begin
                if (value != '0)
                    value <= value - 1'b1;
                else if (!oneshot)
                    value <= load;
            end

            // Hardware set beats a simultaneous write-1-to-clear
            if (expire)
                irq <= 1'b1;
            else if (wr_status && HWDATA[0])
                irq <= 1'b0;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        HRDATA = '0;
        if (dp.rd) begin
            case (dp.addr)
                A_CTRL: begin
                    HRDATA[0]          = en;
                    HRDATA[1]          = ie;
                    HRDATA[2]          = oneshot;
                    HRDATA[8 +: PRE_W] = prescale;
                end
                A_LOAD:  HRDATA[CNT_W-1:0] = load;
                A_VALUE: HRDATA[CNT_W-1:0] = value;
                default: HRDATA[0]         = irq;
            endcase
        end
    end

endmodule
